iccm_port_arbiter: RTL and testbench
====================================

# iccm_port_arbiter

Two-requester arbiter that shares one single-port DFFRAM macro (ICCM or DCCM) between the UART programming path and the TL-UL memory adapter. It sits between the requesters and the `DFFRAM` instance. Each cycle it grants at most one request and drives the macro's EN/WE/A/Di pins. It returns read data to the winning requester one cycle later. Without it, programming writes and core fetches would contend for the macro with no arbitration.

## Interface
Parameters:
- `AW`, 10, word address width; matches DFFRAM `A`.
- `DW`, 32, data width; `DW/8` byte lanes.
- `MAX_BURST`, 8, maximum consecutive A grants in priority mode while B waits; range 1–255.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `prio_a_i` in 1: 1 = programming mode; A has priority, subject to the `MAX_BURST` fairness slot.
- `a_req_i` in 1: port A request. A is the programming writer.
- `a_we_i` in 1: port A access type; 1 = write, 0 = read.
- `a_addr_i` in AW: port A word address.
- `a_wdata_i` in DW: port A write data.
- `a_wmask_i` in DW/8: port A byte-write mask.
- `a_gnt_o` out 1: port A request accepted this cycle.
- `a_rvalid_o` out 1: port A read data valid.
- `a_rdata_o` out DW: port A read data.
- `b_*`: the same set for port B, the TL-UL adapter.
- `ram_en_o` out 1: DFFRAM EN, active-high.
- `ram_we_o` out DW/8: DFFRAM WE byte strobes.
- `ram_addr_o` out AW: DFFRAM address.
- `ram_wdata_o` out DW: DFFRAM write data.
- `ram_rdata_i` in DW: DFFRAM Do, valid the cycle after EN.

## Operation
- Grant is combinational in the request cycle. The request stays asserted and stable until `x_gnt_o`. One grant per cycle at most.
- The granted port's address and data go to the RAM pins in the same cycle.
  - `ram_en_o` = any grant.
  - `ram_we_o` = `x_wmask` if `x_we`, else 0.
  - With no grant, all RAM outputs are 0.
- Normal mode (`prio_a_i` = 0), round-robin:
  - Only one requester: it wins.
  - Both request: the port not granted last wins.
  - `last_grant` register, reset to B, so A wins the first tie.
- Priority mode (`prio_a_i` = 1):
  - A wins ties.
  - `a_streak` counter (8 bit) counts consecutive A grants made while `b_req_i` is high.
  - When `a_streak` = `MAX_BURST` and both request, B wins one cycle and `a_streak` clears.
  - `a_streak` also clears on any cycle with `b_req_i` low, and on any mode change.
- Read return:
  - A read grant sets a 1-cycle response pipe: `rsp_vld` plus `rsp_port`.
  - Next cycle, `x_rvalid_o` asserts for that port only.
  - `x_rdata_o` = `ram_rdata_i` when that port's rvalid is high, else 0.
  - Writes produce no rvalid.
- There is no response backpressure. A grant in cycle N+1 is allowed while the cycle-N read returns.

## Timing
- Reset values: every output 0; `last_grant` = B; `a_streak` = 0; `rsp_vld` = 0.
- Latency:
  - Grant: 0 cycles.
  - Read data: exactly 1 cycle after grant.
  - Write: committed at the clock edge of the grant cycle.
- Throughput: one access per cycle, back-to-back reads and writes mixed freely.
- Read after write, same address, consecutive grants: returns the new data, because the macro writes at the edge before the read.
- Reset asserted mid-operation:
  - A pending rvalid is dropped; no response after deassertion.
  - Requesters must reissue.
- `prio_a_i` changing while requests are pending takes effect in the same cycle's arbitration.

## Structure
- Shared package `iccm_arb_pkg`:
  - `port_e` enum (`PORT_A`, `PORT_B`).
  - Typedef `mem_req_t`: `we`, `addr`, `wdata`, `wmask`.
  - Default `MAX_BURST` constant.
- One natural sub-module, `rr_arb2`: two-input arbiter with `last_grant` state and a priority/fairness override, returning a one-hot grant.
- The top holds the mux, the response pipe and the streak counter.

## Test plan
- Reset, then a single A write (addr 0x005, data 0xDEADBEEF, mask 0xF), then an A read of 0x005 → `a_gnt_o` in the same cycle; `a_rvalid_o` 1 cycle later with 0xDEADBEEF; B outputs stay 0.
- Normal mode, A and B both reading continuously for 6 cycles → grants alternate A, B, A, B, A, B; each rvalid goes to the correct port with the right data.
- Priority mode, `MAX_BURST` = 3, both requesting for 8 cycles → grants A, A, A, B, A, A, A, B.
- Byte mask: write 0x11223344 mask 0xF, then 0xAABBCCDD mask 0x2 to the same address, then read → 0x1122CC44.
- Reset asserted the cycle after a B read grant → `b_rvalid_o` stays 0; all outputs 0 during reset; first post-reset tie goes to A.
- Mode switch: during a tie with `last_grant` = A, assert `prio_a_i` → A wins that cycle; deassert → round-robin resumes.

Source files
------------

// File: rtl/iccm_arb_pkg.sv
// Shared types and defaults for the ICCM/DCCM two-port arbiter.
package iccm_arb_pkg;

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  localparam int DEF_AW        = 10;
  localparam int DEF_DW        = 32;
  localparam int DEF_MAX_BURST = 8;

  // Request payload carried from either port to the RAM pin mux
  typedef struct packed {
    logic                  we;
    logic [DEF_AW-1:0]     addr;
    logic [DEF_DW-1:0]     wdata;
    logic [DEF_DW/8-1:0]   wmask;
  } mem_req_t;

endpackage

// File: rtl/iccm_port_arbiter_if.sv
// Requester A/B handshakes plus the DFFRAM pin bundle for the arbiter.
interface iccm_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic            prio_a_i;
  logic            a_req_i, a_we_i, a_gnt_o, a_rvalid_o;
  logic [AW-1:0]   a_addr_i;
  logic [DW-1:0]   a_wdata_i, a_rdata_o;
  logic [DW/8-1:0] a_wmask_i;
  logic            b_req_i, b_we_i, b_gnt_o, b_rvalid_o;
  logic [AW-1:0]   b_addr_i;
  logic [DW-1:0]   b_wdata_i, b_rdata_o;
  logic [DW/8-1:0] b_wmask_i;
  logic            ram_en_o;
  logic [DW/8-1:0] ram_we_o;
  logic [AW-1:0]   ram_addr_o;
  logic [DW-1:0]   ram_wdata_o, ram_rdata_i;

  modport slave (
    input  prio_a_i,
    input  a_req_i, a_we_i, a_addr_i, a_wdata_i, a_wmask_i,
    output a_gnt_o, a_rvalid_o, a_rdata_o,
    input  b_req_i, b_we_i, b_addr_i, b_wdata_i, b_wmask_i,
    output b_gnt_o, b_rvalid_o, b_rdata_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output prio_a_i,
    output a_req_i, a_we_i, a_addr_i, a_wdata_i, a_wmask_i,
    input  a_gnt_o, a_rvalid_o, a_rdata_o,
    output b_req_i, b_we_i, b_addr_i, b_wdata_i, b_wmask_i,
    input  b_gnt_o, b_rvalid_o, b_rdata_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-input arbiter: round-robin on ties, with an A-priority mode and a
// fairness override that hands one tie to B.
module rr_arb2
  import iccm_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       prio_a,
  input  logic       force_b,
  output logic [1:0] gnt
);

  port_e last_grant, last_grant_d;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) last_grant <= PORT_B;
    else       last_grant <= last_grant_d;

  always_comb begin
    gnt          = req;
    last_grant_d = last_grant;
    if (&req) begin
      if (prio_a) gnt = force_b ? 2'b10 : 2'b01;
      else        gnt = (last_grant == PORT_B) ? 2'b01 : 2'b10;
    end
    if (gnt[0])      last_grant_d = PORT_A;
    else if (gnt[1]) last_grant_d = PORT_B;
  end

endmodule

// File: rtl/iccm_port_arbiter.sv
// Shares one single-port DFFRAM between the UART programmer (A) and the
// TL-UL adapter (B); zero-cycle grant, one-cycle read return.
module iccm_port_arbiter
  import iccm_arb_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                clk_i,
  input  logic                rst_i,
  iccm_port_arbiter_if.slave  bus
);

  logic [1:0] req, gnt;
  logic       force_b, prio_q, rsp_vld;
  port_e      rsp_port;
  logic [7:0] a_streak, a_streak_d;
  mem_req_t   req_a, req_b, sel;

  // Gating with reset keeps every output at 0 while reset is held
  assign req     = {bus.b_req_i, bus.a_req_i} & {2{~rst_i}};
  assign force_b = bus.prio_a_i && (a_streak == 8'(MAX_BURST));

  rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (req),
    .prio_a  (bus.prio_a_i),
    .force_b (force_b),
    .gnt     (gnt)
  );

  assign bus.a_gnt_o = gnt[0];
  assign bus.b_gnt_o = gnt[1];

  // Streak only grows while B is actually being held off in priority mode
  always_comb begin
    a_streak_d = a_streak;
    if (!bus.b_req_i || (bus.prio_a_i != prio_q) || gnt[1]) a_streak_d = '0;
    else if (bus.prio_a_i && gnt[0])                        a_streak_d = a_streak + 8'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      a_streak <= '0;
      prio_q   <= 1'b0;
    end else begin
      a_streak <= a_streak_d;
      prio_q   <= bus.prio_a_i;
    end

  assign req_a = '{we: bus.a_we_i, addr: bus.a_addr_i, wdata: bus.a_wdata_i, wmask: bus.a_wmask_i};
  assign req_b = '{we: bus.b_we_i, addr: bus.b_addr_i, wdata: bus.b_wdata_i, wmask: bus.b_wmask_i};

  always_comb begin
    sel = '0;
    if (gnt[0])      sel = req_a;
    else if (gnt[1]) sel = req_b;
  end

  assign bus.ram_en_o    = |gnt;
  assign bus.ram_we_o    = sel.we ? sel.wmask : '0;
  assign bus.ram_addr_o  = sel.addr;
  assign bus.ram_wdata_o = sel.wdata;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rsp_vld  <= 1'b0;
      rsp_port <= PORT_A;
    end else begin
      rsp_vld  <= (|gnt) && !sel.we;
      rsp_port <= gnt[1] ? PORT_B : PORT_A;
    end

  assign bus.a_rvalid_o = rsp_vld && (rsp_port == PORT_A);
  assign bus.b_rvalid_o = rsp_vld && (rsp_port == PORT_B);
  assign bus.a_rdata_o  = bus.a_rvalid_o ? bus.ram_rdata_i : '0;
  assign bus.b_rdata_o  = bus.b_rvalid_o ? bus.ram_rdata_i : '0;

endmodule

// File: tb/tb_iccm_port_arbiter.sv
// Directed, table-driven bench for iccm_port_arbiter with a behavioural DFFRAM.
module tb_iccm_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  iccm_port_arbiter_if #(.AW(10), .DW(32)) bus ();

  iccm_port_arbiter #(.AW(10), .DW(32), .MAX_BURST(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // DFFRAM model: byte-strobed write at the edge, Do valid the cycle after EN
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.ram_en_o) begin
      for (int i = 0; i < 4; i++)
        if (bus.ram_we_o[i]) mem[bus.ram_addr_o][8*i +: 8] <= bus.ram_wdata_o[8*i +: 8];
      bus.ram_rdata_i <= mem[bus.ram_addr_o];
    end
  end

  typedef struct {
    logic        req, we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } op_t;

  typedef struct {
    logic        prio;
    op_t         a, b;
    logic        ga, gb, rva, rvb;
    logic [31:0] rda, rdb;
  } vec_t;

  function automatic op_t NOP();
    op_t o = '{1'b0, 1'b0, 10'h0, 32'h0, 4'h0};
    return o;
  endfunction
  function automatic op_t RD(input logic [9:0] ad);
    op_t o = '{1'b1, 1'b0, ad, 32'h0, 4'h0};
    return o;
  endfunction
  function automatic op_t WR(input logic [9:0] ad, input logic [31:0] d, input logic [3:0] m);
    op_t o = '{1'b1, 1'b1, ad, d, m};
    return o;
  endfunction
  function automatic vec_t mk(input logic p, input op_t a, input op_t b, input logic ga, input logic gb,
                              input logic rva, input logic [31:0] rda, input logic rvb, input logic [31:0] rdb);
    vec_t v;
    v.prio = p; v.a = a; v.b = b; v.ga = ga; v.gb = gb;
    v.rva = rva; v.rda = rda; v.rvb = rvb; v.rdb = rdb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic p, input op_t a, input op_t b);
    bus.prio_a_i  = p;
    bus.a_req_i   = a.req; bus.a_we_i = a.we; bus.a_addr_i = a.addr;
    bus.a_wdata_i = a.wdata; bus.a_wmask_i = a.mask;
    bus.b_req_i   = b.req; bus.b_we_i = b.we; bus.b_addr_i = b.addr;
    bus.b_wdata_i = b.wdata; bus.b_wmask_i = b.mask;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " a_gnt"},     32'(bus.a_gnt_o),    32'h0);
    chk({tag, " b_gnt"},     32'(bus.b_gnt_o),    32'h0);
    chk({tag, " a_rvalid"},  32'(bus.a_rvalid_o), 32'h0);
    chk({tag, " b_rvalid"},  32'(bus.b_rvalid_o), 32'h0);
    chk({tag, " a_rdata"},   bus.a_rdata_o,       32'h0);
    chk({tag, " b_rdata"},   bus.b_rdata_o,       32'h0);
    chk({tag, " ram_en"},    32'(bus.ram_en_o),   32'h0);
    chk({tag, " ram_we"},    32'(bus.ram_we_o),   32'h0);
    chk({tag, " ram_addr"},  32'(bus.ram_addr_o), 32'h0);
    chk({tag, " ram_wdata"}, bus.ram_wdata_o,     32'h0);
  endtask

  // Inputs at negedge; grants and this cycle's read return checked 1 time unit later
  task automatic apply(input vec_t v, input int idx);
    string t;
    op_t   w;
    t = $sformatf("row%0d", idx);
    @(negedge clk);
    drive(v.prio, v.a, v.b);
    #1;
    chk({t, " a_gnt"},    32'(bus.a_gnt_o),    32'(v.ga));
    chk({t, " b_gnt"},    32'(bus.b_gnt_o),    32'(v.gb));
    chk({t, " a_rvalid"}, 32'(bus.a_rvalid_o), 32'(v.rva));
    chk({t, " b_rvalid"}, 32'(bus.b_rvalid_o), 32'(v.rvb));
    chk({t, " a_rdata"},  bus.a_rdata_o,       v.rda);
    chk({t, " b_rdata"},  bus.b_rdata_o,       v.rdb);
    w = v.ga ? v.a : (v.gb ? v.b : NOP());
    chk({t, " ram_en"},   32'(bus.ram_en_o),   32'(v.ga | v.gb));
    chk({t, " ram_we"},   32'(bus.ram_we_o),   32'(w.we ? w.mask : 4'h0));
    chk({t, " ram_addr"}, 32'(bus.ram_addr_o), 32'(w.addr));
    if (w.we) chk({t, " ram_wdata"}, bus.ram_wdata_o, w.wdata);
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1;
    drive(1'b0, RD(10'h005), RD(10'h021));
    bus.ram_rdata_i = '0;

    // Main table: {prio, A op, B op, exp a_gnt, b_gnt, a_rvalid, a_rdata, b_rvalid, b_rdata}
    // single write/read on A
    tbl.push_back(mk(0, WR(10'h005, 32'hDEADBEEF, 4'hF), NOP(), 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, RD(10'h005), NOP(), 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, NOP(), NOP(), 0, 0, 1, 32'hDEADBEEF, 0, 0));
    // preload, ending with last_grant = B
    tbl.push_back(mk(0, NOP(), WR(10'h020, 32'hB0B0B0B0, 4'hF), 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, WR(10'h010, 32'hA0A0A0A0, 4'hF), NOP(), 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, NOP(), WR(10'h021, 32'hB1B1B1B1, 4'hF), 0, 1, 0, 0, 0, 0));
    // round-robin, both reading for 6 cycles
    tbl.push_back(mk(0, RD(10'h010), RD(10'h020), 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, RD(10'h010), RD(10'h020), 0, 1, 1, 32'hA0A0A0A0, 0, 0));
    tbl.push_back(mk(0, RD(10'h010), RD(10'h020), 1, 0, 0, 0, 1, 32'hB0B0B0B0));
    tbl.push_back(mk(0, RD(10'h010), RD(10'h020), 0, 1, 1, 32'hA0A0A0A0, 0, 0));
    tbl.push_back(mk(0, RD(10'h010), RD(10'h020), 1, 0, 0, 0, 1, 32'hB0B0B0B0));
    tbl.push_back(mk(0, RD(10'h010), RD(10'h020), 0, 1, 1, 32'hA0A0A0A0, 0, 0));
    tbl.push_back(mk(0, NOP(), NOP(), 0, 0, 0, 0, 1, 32'hB0B0B0B0));
    // priority mode with MAX_BURST = 3
    tbl.push_back(mk(1, NOP(), NOP(), 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, RD(10'h005), RD(10'h021), 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, RD(10'h005), RD(10'h021), 1, 0, 1, 32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(1, RD(10'h005), RD(10'h021), 1, 0, 1, 32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(1, RD(10'h005), RD(10'h021), 0, 1, 1, 32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(1, RD(10'h005), RD(10'h021), 1, 0, 0, 0, 1, 32'hB1B1B1B1));
    tbl.push_back(mk(1, RD(10'h005), RD(10'h021), 1, 0, 1, 32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(1, RD(10'h005), RD(10'h021), 1, 0, 1, 32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(1, RD(10'h005), RD(10'h021), 0, 1, 1, 32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(1, NOP(), NOP(), 0, 0, 0, 0, 1, 32'hB1B1B1B1));
    // byte mask merge, then B read-after-write
    tbl.push_back(mk(0, WR(10'h030, 32'h11223344, 4'hF), NOP(), 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, WR(10'h030, 32'hAABBCCDD, 4'h2), NOP(), 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, RD(10'h030), NOP(), 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, NOP(), WR(10'h040, 32'h12345678, 4'hF), 0, 1, 1, 32'h1122CC44, 0, 0));
    tbl.push_back(mk(0, NOP(), RD(10'h040), 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, NOP(), NOP(), 0, 0, 0, 0, 1, 32'h12345678));
    // mode switch during ties
    tbl.push_back(mk(0, RD(10'h010), RD(10'h020), 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, RD(10'h010), RD(10'h020), 1, 0, 1, 32'hA0A0A0A0, 0, 0));
    tbl.push_back(mk(0, RD(10'h010), RD(10'h020), 0, 1, 1, 32'hA0A0A0A0, 0, 0));
    tbl.push_back(mk(0, RD(10'h010), RD(10'h020), 1, 0, 0, 0, 1, 32'hB0B0B0B0));
    tbl.push_back(mk(1, NOP(), RD(10'h021), 0, 1, 1, 32'hA0A0A0A0, 0, 0));
    tbl.push_back(mk(0, NOP(), NOP(), 0, 0, 0, 0, 1, 32'hB1B1B1B1));

    // Reset state with both ports requesting
    @(negedge clk); #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, NOP(), NOP());

    foreach (tbl[i]) apply(tbl[i], i);

    // Reset asserted the cycle after a B read grant drops the response
    @(negedge clk);
    drive(1'b0, NOP(), RD(10'h021));
    #1 chk("midrst b_gnt", 32'(bus.b_gnt_o), 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1'b0, RD(10'h005), RD(10'h021));
    #1 check_zero("midrst");
    @(negedge clk); #1 check_zero("midrst hold");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst a_gnt",    32'(bus.a_gnt_o),    32'h1);
    chk("postrst b_gnt",    32'(bus.b_gnt_o),    32'h0);
    chk("postrst b_rvalid", 32'(bus.b_rvalid_o), 32'h0);
    chk("postrst a_rvalid", 32'(bus.a_rvalid_o), 32'h0);
    @(negedge clk);
    drive(1'b0, NOP(), NOP());
    #1;
    chk("postrst2 a_rvalid", 32'(bus.a_rvalid_o), 32'h1);
    chk("postrst2 a_rdata",  bus.a_rdata_o,       32'hDEADBEEF);
    chk("postrst2 b_rvalid", 32'(bus.b_rvalid_o), 32'h0);
    @(negedge clk); #1;
    chk("idle a_rvalid", 32'(bus.a_rvalid_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
